// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the modulo up/down counter and its prescaler.
package mod_counter_pkg;

    localparam int PSC_W = 8;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    // Out-of-range load values saturate to the top of the count range.
    function automatic logic [32:0] clamp_load(input logic [32:0] val, input logic [32:0] modulus);
        return (val >= modulus) ? (modulus - 33'd1) : val;
    endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Clock-enable prescaler: emits one tick every PRESCALE enabled cycles.
module mod_counter_prescaler
    import mod_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc_q, psc_d;

    assign tick = en && (psc_q == PSC_MAX);

    always_comb begin
        psc_d = psc_q;
        if (clr || tick) psc_d = '0;
        else if (en)     psc_d = psc_q + PSC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) psc_q <= '0;
        else     psc_q <= psc_d;
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with prescaler, load, tc pulse and sticky ovf.
// Optional capture register enabled by defining MOD_COUNTER_CAPTURE_EN.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int     WIDTH    = 3,
    parameter longint MODULUS  = 8,
    parameter int     PRESCALE = 1,
    parameter longint RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
`ifdef MOD_COUNTER_CAPTURE_EN
    input  logic             cap,
    output logic [WIDTH-1:0] cap_val,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_chk_width
        $error("mod_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_chk_mod
        $error("mod_counter: MODULUS must be 2..2^WIDTH");
    end
    if (RST_VAL < 0 || RST_VAL >= MODULUS) begin : g_chk_rst
        $error("mod_counter: RST_VAL must be < MODULUS");
    end
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_chk_psc
        $error("mod_counter: PRESCALE must be 1..256");
    end

    // One extra bit so cnt+1 at the top of a full-width range cannot alias.
    localparam logic [WIDTH:0]   MAX_V = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0]   ONE_V = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   cnt_ext, step_v;
    logic [WIDTH-1:0] load_clamped;
    logic             wrap;
    logic             tick;
    dir_t             dir;

    mod_counter_prescaler #(.PRESCALE(PRESCALE)) u_psc (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    assign dir          = dir_t'(up);
    assign cnt_ext      = {1'b0, cnt_q};
    assign load_clamped = WIDTH'(clamp_load(33'(load_val), 33'(MODULUS)));

    always_comb begin
        wrap   = 1'b0;
        step_v = cnt_ext;
        if (dir == DIR_UP) begin
            wrap   = (cnt_ext == MAX_V);
            step_v = wrap ? '0 : (cnt_ext + ONE_V);
        end else begin
            wrap   = (cnt_q == '0);
            step_v = wrap ? MAX_V : (cnt_ext - ONE_V);
        end
    end

    // Load beats step; ovf_clr applies regardless, but a wrap re-sets ovf.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q & ~ovf_clr;
        if (load) begin
            cnt_d = load_clamped;
        end else if (tick) begin
            cnt_d = WIDTH'(step_v);
            tc_d  = wrap;
            if (wrap) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_V;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

`ifdef MOD_COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] cap_q, cap_d;

    always_comb begin
        cap_d = cap_q;
        if (cap) cap_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) cap_q <= RST_V;
        else     cap_q <= cap_d;
    end

    assign cap_val = cap_q;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: three configurations share one stimulus bus.
module tb_mod_counter;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tc;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, up, load, ovf_clr, cap;
    logic [3:0] load_val;
    logic [2:0] cnt_a;
    logic [3:0] cnt_b, cnt_c;
    logic       tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;
    logic [2:0] cap_a;
    logic [3:0] cap_b, cap_c;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t e, o;

    // prescale table: en per edge and resulting cnt for PRESCALE=3
    int psc_en [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    int psc_cnt[11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(1), .RST_VAL(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[2:0]),
        .ovf_clr(ovf_clr),
`ifdef MOD_COUNTER_CAPTURE_EN
        .cap(cap), .cap_val(cap_a),
`endif
        .cnt(cnt_a), .tc(tc_a), .ovf(ovf_a));

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .RST_VAL(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .ovf_clr(ovf_clr),
`ifdef MOD_COUNTER_CAPTURE_EN
        .cap(cap), .cap_val(cap_b),
`endif
        .cnt(cnt_b), .tc(tc_b), .ovf(ovf_b));

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .RST_VAL(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .ovf_clr(ovf_clr),
`ifdef MOD_COUNTER_CAPTURE_EN
        .cap(cap), .cap_val(cap_c),
`endif
        .cnt(cnt_c), .tc(tc_c), .ovf(ovf_c));

    function automatic exp_t mk(input int c, input logic t, input logic v);
        exp_t r;
        r.cnt = 4'(c);
        r.tc  = t;
        r.ovf = v;
        return r;
    endfunction

    function automatic exp_t obs_a();
        return mk(int'(cnt_a), tc_a, ovf_a);
    endfunction
    function automatic exp_t obs_b();
        return mk(int'(cnt_b), tc_b, ovf_b);
    endfunction
    function automatic exp_t obs_c();
        return mk(int'(cnt_c), tc_c, ovf_c);
    endfunction

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; ovf_clr = 1'b0; cap = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd5; ovf_clr = 1'b0; cap = 1'b0;
        q.push_back(mk(0, 1'b0, 1'b0));
        @(posedge clk); #1;
        e = q.pop_front();
        n_chk++; o = obs_a(); if (o !== e) begin $display("FAIL reset_a got %p want %p", o, e); n_fail++; end
        n_chk++; o = obs_b(); if (o !== e) begin $display("FAIL reset_b got %p want %p", o, e); n_fail++; end
        n_chk++; o = obs_c(); if (o !== e) begin $display("FAIL reset_c got %p want %p", o, e); n_fail++; end
        load = 1'b0; rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_up_wrap();
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            q.push_back(mk(i % 8, i == 8, i >= 8));
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_a(); n_chk++;
            if (o !== e) begin $display("FAIL up_wrap[%0d] got %p want %p", i, o, e); n_fail++; end
        end
    endtask

    task automatic test_down_wrap();
        do_reset();
        en = 1'b1; up = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            q.push_back(mk((10 - i) % 10, i == 1, 1'b1));
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_b(); n_chk++;
            if (o !== e) begin $display("FAIL down_wrap[%0d] got %p want %p", i, o, e); n_fail++; end
        end
    endtask

    task automatic test_prescale();
        do_reset();
        up = 1'b1;
        for (int i = 0; i < 11; i++) begin
            en = psc_en[i][0];
            q.push_back(mk(psc_cnt[i], 1'b0, 1'b0));
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_c(); n_chk++;
            if (o !== e) begin $display("FAIL prescale[%0d] got %p want %p", i, o, e); n_fail++; end
        end
        en = 1'b0;
    endtask

    task automatic test_load();
        do_reset();
        // load 12 clamps to 9; step wraps; clear ovf while stepping; reload 9; load over a wrap
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin en = 1'b0; up = 1'b1; load = 1'b1; load_val = 4'd12; ovf_clr = 1'b0; q.push_back(mk(9, 1'b0, 1'b0)); end
                1: begin en = 1'b1; load = 1'b0;                                q.push_back(mk(0, 1'b1, 1'b1)); end
                2: begin ovf_clr = 1'b1;                                        q.push_back(mk(1, 1'b0, 1'b0)); end
                3: begin ovf_clr = 1'b0; load = 1'b1; load_val = 4'd9;          q.push_back(mk(9, 1'b0, 1'b0)); end
                default: begin load = 1'b1; load_val = 4'd4;                    q.push_back(mk(4, 1'b0, 1'b0)); end
            endcase
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_b(); n_chk++;
            if (o !== e) begin $display("FAIL load[%0d] got %p want %p", i, o, e); n_fail++; end
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_ovf_clr();
        do_reset();
        // wrap+clr keeps ovf, clr alone clears, flip up, count to 5, then reset mid-count
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin en = 1'b1; up = 1'b0; ovf_clr = 1'b1; q.push_back(mk(7, 1'b1, 1'b1)); end
                1: begin en = 1'b0;            ovf_clr = 1'b1; q.push_back(mk(7, 1'b0, 1'b0)); end
                2: begin en = 1'b1; up = 1'b1; ovf_clr = 1'b0; q.push_back(mk(0, 1'b1, 1'b1)); end
                8: begin rst = 1'b1;                           q.push_back(mk(0, 1'b0, 1'b0)); end
                default:                                       q.push_back(mk(i - 2, 1'b0, 1'b1));
            endcase
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_a(); n_chk++;
            if (o !== e) begin $display("FAIL ovf_clr[%0d] got %p want %p", i, o, e); n_fail++; end
        end
        rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin up = 1'b0; q.push_back(mk(7, 1'b1, 1'b1)); end
                1: begin up = 1'b1; q.push_back(mk(0, 1'b1, 1'b1)); end
                2: begin up = 1'b0; q.push_back(mk(7, 1'b1, 1'b1)); end
                default: begin      q.push_back(mk(6, 1'b0, 1'b1)); end
            endcase
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_a(); n_chk++;
            if (o !== e) begin $display("FAIL back_to_back[%0d] got %p want %p", i, o, e); n_fail++; end
        end
        en = 1'b0;
    endtask

`ifdef MOD_COUNTER_CAPTURE_EN
    task automatic test_capture();
        logic [2:0] cq[$];
        logic [2:0] ce;
        do_reset();
        n_chk++; if (cap_a !== 3'd0) begin $display("FAIL cap_reset got %0d want 0", cap_a); n_fail++; end
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cap = (i == 7) || (i == 10);
            ce  = (i < 7) ? 3'd0 : (i < 10) ? 3'd6 : 3'd1;
            cq.push_back(ce);
            @(posedge clk); #1;
            ce = cq.pop_front(); n_chk++;
            if (cap_a !== ce || cnt_a !== 3'(i % 8)) begin
                $display("FAIL capture[%0d] got cap_val=%0d cnt=%0d want cap_val=%0d cnt=%0d", i, cap_a, cnt_a, ce, i % 8);
                n_fail++;
            end
        end
        cap = 1'b0; en = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; ovf_clr = 1'b0; cap = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_prescale();
        test_load();
        test_ovf_clr();
        test_back_to_back();
`ifdef MOD_COUNTER_CAPTURE_EN
        test_capture();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
